// File: rtl/dpram_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_copy_dma
//  Description : Single-clock block-copy engine between two dual-port RAMs.
//                Reads a run of words from a source RAM read port and writes
//                them, in order, to a destination RAM write port. Typically
//                used to snapshot sprite/palette work RAM into the video-side
//                buffer on a frame trigger.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start               - copy request (honoured only when idle)
//                src_base/dst_base   - first source/destination word address
//                length              - number of words to copy (0 allowed)
//                pause               - source port busy; no read issued
//                src_addr / src_q    - source read address / read data (+1 clk)
//                dst_addr/dst_data   - destination write address / data
//                dst_we              - destination byte write enables
//                busy / done         - copy in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module dpram_copy_dma #(
    parameter int DATA_W = 16,
    parameter int SRC_AW = 10,
    parameter int DST_AW = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [DST_AW-1:0] dst_base,
    input  logic [LEN_W-1:0]  length,
    input  logic              pause,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_q,
    output logic [DST_AW-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic [1:0]        dst_we,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [SRC_AW-1:0] r_rd_ptr;
    logic [DST_AW-1:0] r_wr_ptr;
    logic [LEN_W-1:0]  r_remain;
    logic              r_vld;      // a read was issued last cycle; src_q is live now
    logic              r_done;
    logic              w_accept;
    logic              w_issue;
    logic              w_zero_len;

    assign w_zero_len = (length == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (!w_zero_len) begin
                        w_state_nxt = c_RUN;
                    end
                end
            end
            c_RUN: begin
                if (!pause) begin
                    w_issue = 1'b1;
                    if (r_remain == LEN_W'(1)) begin
                        w_state_nxt = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                // Last read is being written this cycle; nothing new issued.
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_remain <= '0;
            r_vld    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_issue;
            // Zero-length requests complete immediately without leaving IDLE.
            r_done  <= (w_accept && w_zero_len) || (r_state == c_DRAIN);

            if (r_vld) begin
                r_wr_ptr <= r_wr_ptr + DST_AW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + SRC_AW'(1);
                r_remain <= r_remain - LEN_W'(1);
            end
            // r_vld and w_issue are always low in IDLE, so no conflict here.
            if (w_accept) begin
                r_rd_ptr <= src_base;
                r_wr_ptr <= dst_base;
                r_remain <= length;
            end
        end
    end

    assign src_addr = r_rd_ptr;
    assign dst_addr = r_wr_ptr;
    assign dst_data = src_q;
    assign dst_we   = {2{r_vld}};
    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dpram_copy_dma.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_copy_dma
//  Description : Self-checking bench for dpram_copy_dma. Source RAM returns
//                16'hC000 | address one clock after the address is sampled
//                (garbage while paused); destination RAM stores writes.
//                Expected writes are queued when a copy is launched and a
//                monitor pops/compares them whenever dst_we is active.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpram_copy_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  src_base = '0;
    logic [9:0]  dst_base = '0;
    logic [10:0] length = '0;
    logic        pause = 1'b0;
    logic [9:0]  src_addr;
    logic [15:0] src_q = '0;
    logic [9:0]  dst_addr;
    logic [15:0] dst_data;
    logic [1:0]  dst_we;
    logic        busy;
    logic        done;

    logic [15:0] dst_mem [0:1023];
    logic [25:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    dpram_copy_dma #(
        .DATA_W(16), .SRC_AW(10), .DST_AW(10), .LEN_W(11)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .pause(pause), .src_addr(src_addr), .src_q(src_q),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] src_word(input logic [9:0] a);
        return 16'hC000 | {6'd0, a};
    endfunction

    // Source RAM: while paused another master owns the port, so data is junk.
    always @(posedge clk) src_q <= pause ? 16'hDEAD : src_word(src_addr);

    always @(posedge clk) if (dst_we == 2'b11) dst_mem[dst_addr] <= dst_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (dst_we != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", {22'd0, dst_addr}, 32'hFFFFFFFF);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", {22'd0, dst_addr}, {22'd0, e[25:16]});
                chk("wr_data", {16'd0, dst_data}, {16'd0, e[15:0]});
                chk("wr_we", {30'd0, dst_we}, 32'd3);
            end
        end
    end

    // Launch one copy at cycle 0 and observe cycles 1.. until done (or reset).
    task automatic run_copy(input string tag, input logic [9:0] sb, input logic [9:0] db,
                            input logic [10:0] len, input logic [31:0] pmask,
                            input int restart_cyc, input int rst_cyc,
                            input int exp_done, input int exp_first_we);
        int  done_c, we_n, first_we, busy_n, done_n;
        bit  aborted;
        done_c = -1; we_n = 0; first_we = -1; busy_n = 0; aborted = 0;
        for (int k = 0; k < int'(len); k++)
            exp_q.push_back({10'(db + 10'(k)), src_word(10'(sb + 10'(k)))});
        @(posedge clk); #1;
        src_base = sb; dst_base = db; length = len; start = 1'b1; pause = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            start = (c == restart_cyc);
            if (start) begin
                src_base = 10'h155; dst_base = 10'h2AA; length = 11'd3;
            end
            pause = (c < 32) ? pmask[c] : 1'b0;
            reset = (c == rst_cyc);
            @(negedge clk);
            if (rst_cyc > 0 && c == rst_cyc + 1) begin
                chk({tag, "_rst_we"}, {30'd0, dst_we}, 32'd0);
                chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
                exp_q.delete();
                aborted = 1;
                break;
            end
            if (busy) busy_n++;
            if (dst_we != 2'b00) begin
                we_n++;
                if (first_we < 0) first_we = c;
            end
            if (done) begin
                done_c = c;
                break;
            end
        end
        start = 1'b0; pause = 1'b0; reset = 1'b0;
        if (aborted) begin
            done_n = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || busy || dst_we != 2'b00) done_n++;
            end
            chk({tag, "_quiet_after_reset"}, done_n, 0);
        end else begin
            chk({tag, "_done_cycle"}, done_c, exp_done);
            chk({tag, "_write_count"}, we_n, 32'(len));
            chk({tag, "_first_write"}, first_we, exp_first_we);
            chk({tag, "_busy_cycles"}, busy_n, exp_done - 1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            @(negedge clk); @(negedge clk);
            chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
            chk({tag, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_src_addr", {22'd0, src_addr}, 32'd0);
        chk("reset_dst_addr", {22'd0, dst_addr}, 32'd0);
        chk("reset_dst_we", {30'd0, dst_we}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: basic copy, writes cycles 2..5, done cycle 6
        run_copy("t1", 10'h100, 10'h000, 11'd4, 32'h0, -1, 0, 6, 2);
        chk("t1_dst0", {16'd0, dst_mem[0]}, 32'h0000C100);
        chk("t1_dst3", {16'd0, dst_mem[3]}, 32'h0000C103);

        // 2: zero length, done one cycle after start, no writes, never busy
        run_copy("t2", 10'h055, 10'h066, 11'd0, 32'h0, -1, 0, 1, -1);

        // 3: pause on cycles 2 and 3 stretches the copy to done at cycle 12
        run_copy("t3", 10'h200, 10'h100, 11'd8, 32'h0000000C, -1, 0, 12, 2);
        chk("t3_dst100", {16'd0, dst_mem[10'h100]}, 32'h0000C200);
        chk("t3_dst104", {16'd0, dst_mem[10'h104]}, 32'h0000C204);
        chk("t3_dst107", {16'd0, dst_mem[10'h107]}, 32'h0000C207);

        // 4: independent wrap of both pointers
        run_copy("t4", 10'h3FE, 10'h3FF, 11'd4, 32'h0, -1, 0, 6, 2);
        chk("t4_dst3ff", {16'd0, dst_mem[10'h3FF]}, 32'h0000C3FE);
        chk("t4_dst000", {16'd0, dst_mem[10'h000]}, 32'h0000C3FF);
        chk("t4_dst001", {16'd0, dst_mem[10'h001]}, 32'h0000C000);
        chk("t4_dst002", {16'd0, dst_mem[10'h002]}, 32'h0000C001);

        // 5: second start mid-copy is ignored
        run_copy("t5", 10'h040, 10'h080, 11'd6, 32'h0, 3, 0, 8, 2);
        chk("t5_dst080", {16'd0, dst_mem[10'h080]}, 32'h0000C040);
        chk("t5_dst085", {16'd0, dst_mem[10'h085]}, 32'h0000C045);

        // 6: reset during the third write of a 16-word copy, then a clean copy
        run_copy("t6", 10'h300, 10'h300, 11'd16, 32'h0, -1, 4, 0, 0);
        run_copy("t6b", 10'h010, 10'h020, 11'd5, 32'h0, -1, 0, 7, 2);
        chk("t6b_dst020", {16'd0, dst_mem[10'h020]}, 32'h0000C010);
        chk("t6b_dst024", {16'd0, dst_mem[10'h024]}, 32'h0000C014);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
